// File: rtl/dcmac_pkt_cnt_pkg.sv
// Shared constants and helper functions for the DCMAC AXIS per-channel
// byte/packet statistics counters.
package dcmac_pkt_cnt_pkg;

   localparam int NUM_SEG = 12;
   localparam int CNT_W   = 32;
   localparam int SIZE_W  = 8;
   localparam int PCNT_W  = 4;
   localparam logic [SIZE_W-1:0] MAX_SIZE = 8'd192;

   function automatic logic [PCNT_W-1:0] popcount12(input logic [NUM_SEG-1:0] v);
      logic [PCNT_W-1:0] c;
      c = {PCNT_W{1'b0}};
      for (int i = 0; i < NUM_SEG; i++) begin
         c = c + {{(PCNT_W-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

   function automatic int id_width(input int num_id);
      return (num_id <= 1) ? 1 : $clog2(num_id);
   endfunction

endpackage

// File: rtl/dcmac_pkt_cnt_lane.sv
// One channel's pair of 32-bit byte/packet counters with synchronous clear;
// the wrap flags are combinational and registered by the parent.
module dcmac_pkt_cnt_lane
   import dcmac_pkt_cnt_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              en_i,
   input  logic [SIZE_W-1:0] byte_add_i,
   input  logic [PCNT_W-1:0] pkt_add_i,
   output logic [CNT_W-1:0]  byte_cnt_o,
   output logic [CNT_W-1:0]  pkt_cnt_o,
   output logic              byte_wrap_o,
   output logic              pkt_wrap_o
);

   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_W:0]   byte_sum_s, pkt_sum_s;

   assign byte_sum_s = {1'b0, byte_cnt_q} + {{(CNT_W+1-SIZE_W){1'b0}}, byte_add_i};
   assign pkt_sum_s  = {1'b0, pkt_cnt_q} + {{(CNT_W+1-PCNT_W){1'b0}}, pkt_add_i};

   // Clear beats an increment in the same cycle and suppresses its wrap
   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      pkt_cnt_d   = pkt_cnt_q;
      byte_wrap_o = 1'b0;
      pkt_wrap_o  = 1'b0;
      if (clear_i) begin
         byte_cnt_d = {CNT_W{1'b0}};
         pkt_cnt_d  = {CNT_W{1'b0}};
      end else if (en_i) begin
         byte_cnt_d  = byte_sum_s[CNT_W-1:0];
         pkt_cnt_d   = pkt_sum_s[CNT_W-1:0];
         byte_wrap_o = byte_sum_s[CNT_W];
         pkt_wrap_o  = pkt_sum_s[CNT_W];
      end else begin
         byte_cnt_d = byte_cnt_q;
         pkt_cnt_d  = pkt_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= {CNT_W{1'b0}};
         pkt_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         byte_cnt_q <= byte_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
      end
   end

   assign byte_cnt_o = byte_cnt_q;
   assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: rtl/dcmac_axis_pkt_stat_cnt.sv
// Per-channel 32-bit byte/packet statistics with chainable carry outputs.
// Optional simulation checks on input ranges: define DCMAC_PKT_CNT_ASSERT_EN.
module dcmac_axis_pkt_stat_cnt
   import dcmac_pkt_cnt_pkg::*;
#(
   parameter  int NUM_ID         = 6,
   parameter  int REGISTER_INPUT = 0,
   localparam int ID_W           = id_width(NUM_ID)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_ID-1:0]            i_clear_counters,
   input  logic [ID_W-1:0]              i_id_m1,
   input  logic [NUM_SEG-1:0]           i_sop,
   input  logic [NUM_SEG-1:0]           i_eop,
   input  logic [SIZE_W-1:0]            i_size,
   output logic [ID_W-1:0]              o_carry_id_m1,
   output logic                         o_byte_cnt_carry,
   output logic                         o_pkt_cnt_carry,
   output logic [NUM_ID-1:0][CNT_W-1:0] o_byte_cnt,
   output logic [NUM_ID-1:0][CNT_W-1:0] o_pkt_cnt
);

   logic [ID_W-1:0]    id_in_s;
   logic [NUM_SEG-1:0] sop_in_s;
   logic [NUM_SEG-1:0] eop_in_s;
   logic [SIZE_W-1:0]  size_in_s;
   logic [ID_W-1:0]    id_q;
   logic [PCNT_W-1:0]  pkt_add_s;
   logic [NUM_ID-1:0]  byte_wrap_s;
   logic [NUM_ID-1:0]  pkt_wrap_s;
   logic               byte_carry_q, byte_carry_d;
   logic               pkt_carry_q, pkt_carry_d;
   logic               unused_sop_s;

   generate
      if (REGISTER_INPUT != 0) begin : g_in_reg
         logic [ID_W-1:0]    in_id_q;
         logic [NUM_SEG-1:0] in_sop_q;
         logic [NUM_SEG-1:0] in_eop_q;
         logic [SIZE_W-1:0]  in_size_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               in_id_q   <= {ID_W{1'b0}};
               in_sop_q  <= {NUM_SEG{1'b0}};
               in_eop_q  <= {NUM_SEG{1'b0}};
               in_size_q <= {SIZE_W{1'b0}};
            end else begin
               in_id_q   <= i_id_m1;
               in_sop_q  <= i_sop;
               in_eop_q  <= i_eop;
               in_size_q <= i_size;
            end
         end

         assign id_in_s   = in_id_q;
         assign sop_in_s  = in_sop_q;
         assign eop_in_s  = in_eop_q;
         assign size_in_s = in_size_q;
      end else begin : g_in_direct
         assign id_in_s   = i_id_m1;
         assign sop_in_s  = i_sop;
         assign eop_in_s  = i_eop;
         assign size_in_s = i_size;
      end
   endgenerate

   // Start-of-packet flags are carried for interface symmetry only
   assign unused_sop_s = ^sop_in_s;
   assign pkt_add_s    = popcount12(eop_in_s);
   assign byte_carry_d = |byte_wrap_s;
   assign pkt_carry_d  = |pkt_wrap_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_q         <= {ID_W{1'b0}};
         byte_carry_q <= 1'b0;
         pkt_carry_q  <= 1'b0;
      end else begin
         id_q         <= id_in_s;
         byte_carry_q <= byte_carry_d;
         pkt_carry_q  <= pkt_carry_d;
      end
   end

   // An id_q outside 0..NUM_ID-1 selects no lane, so nothing counts or carries
   for (genvar k = 0; k < NUM_ID; k++) begin : g_lane
      localparam logic [ID_W-1:0] LANE_ID = ID_W'(k);

      dcmac_pkt_cnt_lane u_lane (
         .clk         (clk),
         .rst         (rst),
         .clear_i     (i_clear_counters[k]),
         .en_i        (id_q == LANE_ID),
         .byte_add_i  (size_in_s),
         .pkt_add_i   (pkt_add_s),
         .byte_cnt_o  (o_byte_cnt[k]),
         .pkt_cnt_o   (o_pkt_cnt[k]),
         .byte_wrap_o (byte_wrap_s[k]),
         .pkt_wrap_o  (pkt_wrap_s[k])
      );
   end

   assign o_carry_id_m1    = id_q;
   assign o_byte_cnt_carry = byte_carry_q;
   assign o_pkt_cnt_carry  = pkt_carry_q;

`ifdef DCMAC_PKT_CNT_ASSERT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (size_in_s <= MAX_SIZE)
            else $error("dcmac_axis_pkt_stat_cnt: size %0d above %0d", size_in_s, MAX_SIZE);
         assert (!((32'(id_q) >= NUM_ID) && ((size_in_s != {SIZE_W{1'b0}}) || (eop_in_s != {NUM_SEG{1'b0}}))))
            else $error("dcmac_axis_pkt_stat_cnt: nonzero increment for id %0d", id_q);
      end else begin
      end
   end
`endif

endmodule

// File: tb/tb_dcmac_axis_pkt_stat_cnt.sv
// Directed bench: a base instance, a chained upper instance fed by its
// carries, and a REGISTER_INPUT=1 instance sharing the same stimulus.
module tb_dcmac_axis_pkt_stat_cnt;

   logic              clk;
   logic              rst;
   logic [5:0]        clr;
   logic [2:0]        id_m1;
   logic [11:0]       sop;
   logic [11:0]       eop;
   logic [7:0]        size;

   logic [2:0]        lo_cid;
   logic              lo_bc, lo_pc;
   logic [5:0][31:0]  lo_byte, lo_pkt;

   logic [5:0]        hi_clr;
   logic [11:0]       hi_sop;
   logic [7:0]        hi_size;
   logic [11:0]       hi_eop;
   logic [2:0]        hi_cid;
   logic              hi_bc, hi_pc;
   logic [5:0][31:0]  hi_byte, hi_pkt;

   logic [2:0]        rg_cid;
   logic              rg_bc, rg_pc;
   logic [5:0][31:0]  rg_byte, rg_pkt;

   int checks   = 0;
   int failures = 0;

   assign hi_clr  = 6'd0;
   assign hi_sop  = 12'd0;
   assign hi_size = {7'd0, lo_bc};
   assign hi_eop  = {11'd0, lo_pc};

   dcmac_axis_pkt_stat_cnt #(.NUM_ID(6), .REGISTER_INPUT(0)) u_lo (
      .clk(clk), .rst(rst), .i_clear_counters(clr), .i_id_m1(id_m1),
      .i_sop(sop), .i_eop(eop), .i_size(size),
      .o_carry_id_m1(lo_cid), .o_byte_cnt_carry(lo_bc), .o_pkt_cnt_carry(lo_pc),
      .o_byte_cnt(lo_byte), .o_pkt_cnt(lo_pkt));

   dcmac_axis_pkt_stat_cnt #(.NUM_ID(6), .REGISTER_INPUT(0)) u_hi (
      .clk(clk), .rst(rst), .i_clear_counters(hi_clr), .i_id_m1(lo_cid),
      .i_sop(hi_sop), .i_eop(hi_eop), .i_size(hi_size),
      .o_carry_id_m1(hi_cid), .o_byte_cnt_carry(hi_bc), .o_pkt_cnt_carry(hi_pc),
      .o_byte_cnt(hi_byte), .o_pkt_cnt(hi_pkt));

   dcmac_axis_pkt_stat_cnt #(.NUM_ID(6), .REGISTER_INPUT(1)) u_rg (
      .clk(clk), .rst(rst), .i_clear_counters(clr), .i_id_m1(id_m1),
      .i_sop(sop), .i_eop(eop), .i_size(size),
      .o_carry_id_m1(rg_cid), .o_byte_cnt_carry(rg_bc), .o_pkt_cnt_carry(rg_pc),
      .o_byte_cnt(rg_byte), .o_pkt_cnt(rg_pkt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present next id plus this cycle's size/eop, then move to the next falling edge
   task automatic apply(input logic [2:0] nid, input logic [7:0] sz, input logic [11:0] ep);
      id_m1 = nid;
      size  = sz;
      eop   = ep;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; clr = 6'd0; id_m1 = 3'd6; sop = 12'd0; eop = 12'd0; size = 8'd0;
      apply(3'd6, 8'd0, 12'd0);
      apply(3'd6, 8'd0, 12'd0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("rst_byte%0d", k), lo_byte[k], 32'd0);
         chk($sformatf("rst_pkt%0d", k), lo_pkt[k], 32'd0);
      end
      chk("rst_cid", 32'(lo_cid), 32'd0);
      chk("rst_bcarry", 32'(lo_bc), 32'd0);
      chk("rst_pcarry", 32'(lo_pc), 32'd0);

      // Basic count on channel 2
      apply(3'd2, 8'd0, 12'd0);
      chk("basic_cid", 32'(lo_cid), 32'd2);
      apply(3'd6, 8'd100, 12'h001);
      chk("basic_byte2", lo_byte[2], 32'd100);
      chk("basic_pkt2", lo_pkt[2], 32'd1);
      chk("basic_byte0", lo_byte[0], 32'd0);
      chk("basic_byte3", lo_byte[3], 32'd0);
      chk("basic_bcarry", 32'(lo_bc), 32'd0);
      chk("basic_pcarry", 32'(lo_pc), 32'd0);
      chk("reg_byte2_early", rg_byte[2], 32'd0);
      apply(3'd0, 8'd0, 12'd0);
      chk("reg_byte2", rg_byte[2], 32'd100);
      chk("reg_pkt2", rg_pkt[2], 32'd1);

      // Several EOPs in one beat
      apply(3'd6, 8'd192, 12'h841);
      chk("multi_byte0", lo_byte[0], 32'd192);
      chk("multi_pkt0", lo_pkt[0], 32'd3);

      // Clear collides with an increment to the same channel
      apply(3'd2, 8'd0, 12'd0);
      clr = 6'b000100;
      apply(3'd3, 8'd50, 12'h001);
      clr = 6'd0;
      chk("clr_byte2", lo_byte[2], 32'd0);
      chk("clr_pkt2", lo_pkt[2], 32'd0);
      chk("clr_bcarry", 32'(lo_bc), 32'd0);
      chk("clr_byte0", lo_byte[0], 32'd192);
      apply(3'd6, 8'd40, 12'h003);
      chk("after_clr_byte3", lo_byte[3], 32'd40);
      chk("after_clr_pkt3", lo_pkt[3], 32'd2);
      chk("after_clr_byte2", lo_byte[2], 32'd0);

      // Out-of-range id changes nothing
      apply(3'd6, 8'd77, 12'h001);
      chk("oor_byte3", lo_byte[3], 32'd40);
      chk("oor_byte0", lo_byte[0], 32'd192);
      chk("oor_pkt0", lo_pkt[0], 32'd3);
      chk("oor_bcarry", 32'(lo_bc), 32'd0);

      // Preload near the wrap point
      force u_lo.g_lane[1].u_lane.byte_cnt_q = 32'hFFFF_FF80;
      force u_lo.g_lane[4].u_lane.byte_cnt_q = 32'hFFFF_FFFF;
      force u_lo.g_lane[4].u_lane.pkt_cnt_q  = 32'hFFFF_FFFE;
      apply(3'd6, 8'd0, 12'd0);
      release u_lo.g_lane[1].u_lane.byte_cnt_q;
      release u_lo.g_lane[4].u_lane.byte_cnt_q;
      release u_lo.g_lane[4].u_lane.pkt_cnt_q;
      chk("pre_byte1", lo_byte[1], 32'hFFFF_FF80);

      apply(3'd1, 8'd0, 12'd0);
      chk("wrap_cid_lead", 32'(lo_cid), 32'd1);
      chk("wrap_bcarry_early", 32'(lo_bc), 32'd0);
      apply(3'd6, 8'd192, 12'd0);
      chk("wrap_byte1", lo_byte[1], 32'h0000_0040);
      chk("wrap_bcarry", 32'(lo_bc), 32'd1);
      chk("wrap_pcarry", 32'(lo_pc), 32'd0);
      apply(3'd4, 8'd0, 12'd0);
      chk("wrap_bcarry_pulse", 32'(lo_bc), 32'd0);
      chk("hi_byte1", hi_byte[1], 32'd1);
      chk("hi_pkt1", hi_pkt[1], 32'd0);
      apply(3'd6, 8'd1, 12'h007);
      chk("dual_byte4", lo_byte[4], 32'd0);
      chk("dual_pkt4", lo_pkt[4], 32'd1);
      chk("dual_bcarry", 32'(lo_bc), 32'd1);
      chk("dual_pcarry", 32'(lo_pc), 32'd1);
      apply(3'd6, 8'd0, 12'd0);
      chk("hi_byte4", hi_byte[4], 32'd1);
      chk("hi_pkt4", hi_pkt[4], 32'd1);
      chk("dual_pcarry_pulse", 32'(lo_pc), 32'd0);

      // Reset while traffic is in flight
      apply(3'd0, 8'd0, 12'd0);
      apply(3'd1, 8'd10, 12'h001);
      chk("pre_rst_byte0", lo_byte[0], 32'd202);
      rst = 1'b1;
      apply(3'd2, 8'd20, 12'h001);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("mid_rst_byte%0d", k), lo_byte[k], 32'd0);
         chk($sformatf("mid_rst_pkt%0d", k), lo_pkt[k], 32'd0);
      end
      chk("mid_rst_hi_byte1", hi_byte[1], 32'd0);
      chk("mid_rst_cid", 32'(lo_cid), 32'd0);
      apply(3'd6, 8'd0, 12'd0);
      chk("post_rst_byte1", lo_byte[1], 32'd0);
      chk("post_rst_byte2", lo_byte[2], 32'd0);
      chk("post_rst_bcarry", 32'(lo_bc), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
